// File: rtl/v_value_pkg.sv
// Shared types and default widths for the v-value read path.
//   DATA_WIDTH / ADDR_WIDTH : default width of one v value and the RAM address
//   rd_state_t              : burst reader FSM states
//   fifo_entry_t            : one output FIFO entry at the default width
package v_value_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } rd_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } fifo_entry_t;

endpackage

// File: rtl/v_value_stream_reader_if.sv
// Valid/ready stream carrying v values from the reader to the residual consumer.
//   out_data  : streamed v value (FIFO head)
//   out_valid : out_data valid
//   out_ready : consumer accepts; transfer = out_valid & out_ready
//   out_last  : final word of the burst
// master = reader side, slave = consumer side.
interface v_value_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/v_rd_skid_fifo.sv
// Small synchronous FIFO used as the reader's output buffer.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/wdata_i: write one entry (caller guarantees not full)
//   pop_i         : drop the head entry (caller guarantees not empty)
//   rdata_o       : head entry
//   count_o       : number of stored entries
// Simultaneous push and pop at full is legal and leaves the count unchanged.
module v_rd_skid_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_q <= count_q + CntW'(1);
      else if (!push_i && pop_i) count_q <= count_q - CntW'(1);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/v_value_stream_reader.sv
// Burst reader for the v-value RAM (1-cycle read latency, registered read address).
// On start, reads len consecutive words from base_addr (wrapping) and streams them out.
// A read issues only while FIFO occupancy plus the in-flight read leaves room, so the
// returning RAM word can always be captured.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : begin a burst (sampled only when idle)
//   base_addr, len  : first address, word count 0..2**ADDR_WIDTH
//   ram_rd_addr     : RAM read address (registered)
//   ram_q           : RAM read data for the address presented last cycle
//   wr_we/addr/data : snoop of the RAM write port
//   out_if          : valid/ready output stream (master)
//   busy, done      : burst in progress / one-cycle completion pulse
// Option V_RD_FWD_EN: a write hitting the in-flight read address in the capture cycle is
// forwarded into the FIFO instead of the stale RAM word.
module v_value_stream_reader #(
  parameter int unsigned DATA_WIDTH = v_value_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = v_value_pkg::ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  input  logic                  wr_we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  v_value_stream_reader_if.master out_if,
  output logic                  busy,
  output logic                  done
);

  import v_value_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  inflight_q, inflight_last_q;
  logic                  issue, pop, head_last;
  logic [DATA_WIDTH-1:0] cap_data, head_data;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [CntW-1:0]       fifo_count;
  logic [CntW:0]         occupancy;

  assign occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    issue       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rd_ptr_d    = base_addr;
          remaining_d = len;
          // An empty burst still spends one busy cycle before done.
          state_d     = (len == '0) ? StDrain : StRun;
        end
      end
      StRun: begin
        if (occupancy < (CntW + 1)'(FIFO_DEPTH)) begin
          issue       = 1'b1;
          rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
          if (remaining_q == (ADDR_WIDTH + 1)'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave as the last word transfers so done lands the following cycle.
        if ((pop && head_last) || (fifo_count == '0 && !inflight_q)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      rd_ptr_q        <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == (ADDR_WIDTH + 1)'(1));
    end
  end

`ifdef V_RD_FWD_EN
  logic [ADDR_WIDTH-1:0] inflight_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     inflight_addr_q <= '0;
    else if (issue) inflight_addr_q <= rd_ptr_q;
  end

  assign cap_data = (wr_we && (wr_addr == inflight_addr_q)) ? wr_data : ram_q;
`else
  logic unused_wr_snoop;
  assign unused_wr_snoop = ^{wr_we, wr_addr, wr_data};
  assign cap_data        = ram_q;
`endif

  v_rd_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (inflight_q),
    .wdata_i ({inflight_last_q, cap_data}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign head_last = fifo_rdata[DATA_WIDTH];
  assign head_data = fifo_rdata[DATA_WIDTH-1:0];

  assign out_if.out_valid = (fifo_count != '0);
  assign out_if.out_data  = out_if.out_valid ? head_data : '0;
  assign out_if.out_last  = out_if.out_valid && head_last;
  assign pop              = out_if.out_valid && out_if.out_ready;

  assign ram_rd_addr = rd_ptr_q;
  assign busy        = (state_q == StRun) || (state_q == StDrain);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_v_value_stream_reader.sv
// Self-checking bench: behavioural RAM, random bursts and backpressure, and an
// expected-word queue built from the RAM contents for each burst.
module tb_v_value_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] base_addr;
  logic [7:0] len;
  logic [6:0] ram_rd_addr;
  logic [7:0] ram_q;
  logic       wr_we;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, done;

  logic [7:0] mem [128];

  int tests = 0;
  int fails = 0;

  v_value_stream_reader_if #(.DATA_WIDTH(8)) sif ();

  v_value_stream_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .ram_rd_addr (ram_rd_addr),
    .ram_q       (ram_q),
    .wr_we       (wr_we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .out_if      (sif),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // RAM: registered read address, read-before-write on collision.
  always @(posedge clk) begin
    ram_q <= mem[ram_rd_addr];
    if (wr_we) mem[wr_addr] <= wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  // mode: 0 ready always, 1 pattern 1,0,0,1, 2 random. restart: pulse start in cycle 2.
  // fwd_cyc >= 0: write 0x55 to base_addr during that cycle.
  task automatic run_burst(input int b, input int l, input int mode, input bit restart,
                           input int fwd_cyc);
    logic [7:0] expq[$];
    int idx, cyc, done_cyc, first_cyc;
    bit got_done, stalled;
    logic [7:0] held_d;
    logic held_l;
    for (int i = 0; i < l; i++) expq.push_back(mem[7'((b + i) % 128)]);
`ifdef V_RD_FWD_EN
    if (fwd_cyc >= 0) expq[0] = 8'h55;
`endif
    idx = 0; cyc = 0; done_cyc = -1; first_cyc = -1; got_done = 0; stalled = 0;
    held_d = '0; held_l = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 7'(b); len = 8'(l);
    sif.out_ready = ready_for(mode, 0);
    while (!got_done && cyc < 1000) begin
      if (cyc == fwd_cyc) begin
        wr_we = 1'b1; wr_addr = 7'(b); wr_data = 8'h55;
      end else begin
        wr_we = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) check("busy_c0", busy, 0);
      if (done) begin
        got_done = 1; done_cyc = cyc;
        check("busy_at_done", busy, 0);
        check("words_at_done", idx, l);
      end else if (cyc >= 1) begin
        check("busy_run", busy, 1);
      end
      if (stalled) begin
        check("stall_valid", sif.out_valid, 1);
        check("stall_data", sif.out_data, held_d);
        check("stall_last", sif.out_last, held_l);
      end
      if (sif.out_valid && sif.out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        check("word_in_burst", idx < l, 1);
        if (idx < l) begin
          check("data", sif.out_data, expq[idx]);
          check("last", sif.out_last, idx == l - 1);
        end
        idx++;
      end
      stalled = sif.out_valid && !sif.out_ready;
      held_d  = sif.out_data;
      held_l  = sif.out_last;
      @(posedge clk); #1;
      start = restart && (cyc == 1);
      base_addr = 7'($urandom); len = 8'($urandom_range(1, 9));
      cyc++;
      sif.out_ready = ready_for(mode, cyc);
    end
    start = 1'b0; wr_we = 1'b0;
    check("done_seen", got_done, 1);
    if (mode == 0) begin
      check("first_valid_cycle", first_cyc, (l == 0) ? -1 : 3);
      check("done_cycle", done_cyc, (l == 0) ? 2 : l + 3);
    end
  endtask

  initial begin
    int ndone;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i + 1);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    wr_we = 1'b0; wr_addr = '0; wr_data = '0; sif.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", sif.out_valid, 0);
    check("rst_last", sif.out_last, 0);
    check("rst_data", sif.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", ram_rd_addr, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_burst(5, 4, 0, 0, -1);
    run_burst(126, 4, 0, 0, -1);
    run_burst(0, 8, 1, 0, -1);
    run_burst(0, 0, 0, 0, -1);
    run_burst(30, 6, 0, 1, -1);
    mem[10] = 8'h11;
    run_burst(10, 1, 0, 0, 2);

    for (int k = 0; k < 20; k++)
      run_burst(int'($urandom_range(0, 127)), int'($urandom_range(0, 20)),
                (k % 2) * 2, 0, -1);
    run_burst(int'($urandom_range(0, 127)), 128, 2, 0, -1);
    run_burst(int'($urandom_range(0, 127)), 128, 0, 0, -1);

    // Reset in the middle of a burst.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 7'd20; len = 8'd10;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_valid", sif.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rd_addr", ram_rd_addr, 0);
    check("midrst_data", sif.out_data, 0);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || sif.out_valid || busy) ndone++;
    end
    check("midrst_quiet", ndone, 0);
    run_burst(100, 5, 2, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
